// File: rtl/laser_frame_ctrl_if.sv
// rtl/laser_frame_ctrl_if.sv - Video-stream and detector signal bundle for laser_frame_ctrl
//
// Groups the pixel qualifiers coming from the video stream together with the
// detector control/result signals.
//   master : the frame controller (samples stream + detector result, drives detector controls)
//   slave  : the environment (video source + spot detector)
// Signals:
//   pix_valid, sof, eof     pixel qualifier, start of frame, end of frame (last pixel)
//   det_found, det_xy       detector result {x,y}
//   det_en                  detector enable
//   det_reset_n             active-low synchronous clear to detector
//   det_threshold           active (shadowed) threshold
interface laser_frame_ctrl_if #(
    parameter int COORD_W = 16
);
    logic                   pix_valid;
    logic                   sof;
    logic                   eof;
    logic                   det_found;
    logic [2*COORD_W-1:0]   det_xy;
    logic                   det_en;
    logic                   det_reset_n;
    logic [7:0]             det_threshold;

    modport master (
        input  pix_valid, sof, eof, det_found, det_xy,
        output det_en, det_reset_n, det_threshold
    );

    modport slave (
        output pix_valid, sof, eof, det_found, det_xy,
        input  det_en, det_reset_n, det_threshold
    );
endinterface

// File: rtl/laser_frame_ctrl.sv
// rtl/laser_frame_ctrl.sv - Frame-level sequencer for the laser-spot detector
//
// Arms and clears the detector once per processed frame, loads a shadowed
// threshold at the frame boundary, gates the detector enable to the active
// frame, then samples and publishes the detector result. After each processed
// frame, `skip` frames are let through unprocessed.
//
// Optional feature macro: LASER_FRAME_CTRL_TIMEOUT_EN
//   defined   : counts consecutive missed frames; at MISS_LIMIT raises laser_lost
//               and zeroes laser_xy until the next found frame.
//   undefined : laser_lost is tied low and laser_xy holds the last found value.
//
// Ports:
//   clk, reset        system clock, synchronous active-high reset
//   enable            software run bit
//   threshold_in/_wr  new detector threshold and its one-cycle write strobe
//   skip              frames to skip after each processed frame (sampled in REPORT)
//   vif               stream/detector bundle (master modport)
//   laser_xy          published result {x,y}
//   laser_found       det_found of the last reported frame
//   result_valid      one-cycle pulse per reported frame, aligned with the published values
//   frame_count       reported-frame counter, wraps
//   frame_err         sticky truncated-frame flag, cleared on entering IDLE
//   busy              controller not idle
//   laser_lost        see optional feature
module laser_frame_ctrl #(
    parameter int           COORD_W     = 16,
    parameter int           FRAME_CNT_W = 16,
    parameter logic [7:0]   THRESH_RST  = 8'd200,
    parameter int           MISS_LIMIT  = 8
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    enable,
    input  logic [7:0]              threshold_in,
    input  logic                    threshold_wr,
    input  logic [3:0]              skip,
    laser_frame_ctrl_if.master      vif,
    output logic [2*COORD_W-1:0]    laser_xy,
    output logic                    laser_found,
    output logic                    result_valid,
    output logic [FRAME_CNT_W-1:0]  frame_count,
    output logic                    frame_err,
    output logic                    busy,
    output logic                    laser_lost
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_ARM,
        S_WAIT_SOF,
        S_ACTIVE,
        S_DRAIN,
        S_REPORT,
        S_SKIP
    } state_t;

    state_t         state;
    logic [7:0]     pending_thr;
    logic [7:0]     active_thr;
    logic           det_reset_n_q;
    logic           drain_cnt;
    logic [3:0]     skip_cnt;

    logic           pix_sof;
    logic           pix_eof;

    assign pix_sof = vif.pix_valid & vif.sof;
    assign pix_eof = vif.pix_valid & vif.eof;

    // The sof pixel itself is seen while still in WAIT_SOF, so it is enabled
    // directly from the stream rather than waiting for ACTIVE.
    assign vif.det_en        = vif.pix_valid &&
                               (state == S_ACTIVE || (state == S_WAIT_SOF && vif.sof));
    assign vif.det_reset_n   = det_reset_n_q;
    assign vif.det_threshold = active_thr;
    assign busy              = (state != S_IDLE);

`ifdef LASER_FRAME_CTRL_TIMEOUT_EN
    logic [7:0]     miss_cnt;
    logic           laser_lost_q;
    assign laser_lost = laser_lost_q;
`else
    assign laser_lost = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (reset) begin
            state         <= S_IDLE;
            pending_thr   <= THRESH_RST;
            active_thr    <= THRESH_RST;
            det_reset_n_q <= 1'b1;
            drain_cnt     <= 1'b0;
            skip_cnt      <= 4'd0;
            laser_xy      <= '0;
            laser_found   <= 1'b0;
            result_valid  <= 1'b0;
            frame_count   <= '0;
            frame_err     <= 1'b0;
`ifdef LASER_FRAME_CTRL_TIMEOUT_EN
            miss_cnt      <= 8'd0;
            laser_lost_q  <= 1'b0;
`endif
        end else begin
            result_valid  <= 1'b0;
            // det_reset_n is low exactly for the cycle spent in ARM: it is
            // dropped on every transition into ARM and released otherwise.
            det_reset_n_q <= 1'b1;

            if (threshold_wr) begin
                pending_thr <= threshold_in;
            end

            case (state)
                S_IDLE: begin
                    if (enable) begin
                        state         <= S_ARM;
                        det_reset_n_q <= 1'b0;
                    end
                end

                S_ARM: begin
                    // A write landing in this very cycle is taken immediately.
                    active_thr <= threshold_wr ? threshold_in : pending_thr;
                    state      <= S_WAIT_SOF;
                end

                S_WAIT_SOF: begin
                    if (!enable) begin
                        state     <= S_IDLE;
                        frame_err <= 1'b0;
                    end else if (pix_sof) begin
                        state     <= pix_eof ? S_DRAIN : S_ACTIVE;
                        drain_cnt <= 1'b0;
                    end
                end

                S_ACTIVE: begin
                    if (!enable) begin
                        state     <= S_IDLE;
                        frame_err <= 1'b0;
                    end else if (pix_eof) begin
                        state     <= S_DRAIN;
                        drain_cnt <= 1'b0;
                    end else if (pix_sof) begin
                        // Truncated frame: drop it and re-arm; the new sof is
                        // lost because the detector must be cleared first.
                        frame_err     <= 1'b1;
                        state         <= S_ARM;
                        det_reset_n_q <= 1'b0;
                    end
                end

                S_DRAIN: begin
                    drain_cnt <= 1'b1;
                    if (drain_cnt) begin
                        state <= S_REPORT;
                    end
                end

                S_REPORT: begin
                    result_valid <= 1'b1;
                    laser_found  <= vif.det_found;
                    frame_count  <= frame_count + 1'b1;
`ifdef LASER_FRAME_CTRL_TIMEOUT_EN
                    if (vif.det_found) begin
                        laser_xy     <= vif.det_xy;
                        miss_cnt     <= 8'd0;
                        laser_lost_q <= 1'b0;
                    end else begin
                        if (miss_cnt != 8'hFF) begin
                            miss_cnt <= miss_cnt + 8'd1;
                        end
                        // Compare against the pre-increment value so the flag
                        // rises in the same REPORT that reaches the limit.
                        if ({24'd0, miss_cnt} >= MISS_LIMIT - 1) begin
                            laser_lost_q <= 1'b1;
                            laser_xy     <= '0;
                        end
                    end
`else
                    if (vif.det_found) begin
                        laser_xy <= vif.det_xy;
                    end
`endif
                    if (!enable) begin
                        state     <= S_IDLE;
                        frame_err <= 1'b0;
                    end else if (skip == 4'd0) begin
                        state         <= S_ARM;
                        det_reset_n_q <= 1'b0;
                    end else begin
                        state    <= S_SKIP;
                        skip_cnt <= skip;
                    end
                end

                S_SKIP: begin
                    if (!enable) begin
                        state     <= S_IDLE;
                        frame_err <= 1'b0;
                    end else if (pix_eof) begin
                        if (skip_cnt == 4'd1) begin
                            state         <= S_ARM;
                            det_reset_n_q <= 1'b0;
                        end else begin
                            skip_cnt <= skip_cnt - 4'd1;
                        end
                    end
                end

                default: begin
                    state <= S_IDLE;
                end
            endcase
        end
    end

endmodule

// File: doc/laser_frame_ctrl.md
Name: laser_frame_ctrl

Overview:
- Frame-level sequencer for the laser-spot detector in the image processing IP.
- Each processed frame it clears and arms the detector and loads a shadowed threshold at a frame boundary.
- Gates detector enable to the active frame, then samples the detector result after the frame and publishes it to the register interface.
- Supports frame decimation (process 1 frame, skip N frames).

Parameters:
- COORD_W, 16, width of each coordinate half of the xy words
- FRAME_CNT_W, 16, width of the processed-frame counter
- THRESH_RST, 8'd200, reset value of the pending and active thresholds
- MISS_LIMIT, 8, consecutive missed frames before laser_lost (optional feature only)

Ports:
- clk  in  1  system clock
- reset  in  1  synchronous, active-high reset
- enable  in  1  software run bit
- pix_valid  in  1  pixel qualifier from video stream
- sof  in  1  start of frame; meaningful only with pix_valid
- eof  in  1  end of frame, last pixel; meaningful only with pix_valid
- threshold_in  in  8  new detector threshold from register
- threshold_wr  in  1  one-cycle write strobe for threshold_in
- skip  in  4  frames to skip after each processed frame
- det_found  in  1  detector locked on a spot this frame
- det_xy  in  2*COORD_W  detector result {x,y}
- det_en  out  1  detector enable
- det_reset_n  out  1  active-low synchronous clear to detector
- det_threshold  out  8  active (shadowed) threshold to detector
- laser_xy  out  2*COORD_W  published result
- laser_found  out  1  det_found of last reported frame
- result_valid  out  1  one-cycle pulse per reported frame
- frame_count  out  FRAME_CNT_W  reported-frame counter, wraps
- frame_err  out  1  sticky truncated-frame flag
- busy  out  1  state != IDLE
- laser_lost  out  1  see optional feature

Behaviour:
- Reset values:
  - state IDLE, det_reset_n 1, det_en 0
  - det_threshold and pending threshold THRESH_RST
  - laser_xy 0, laser_found 0, result_valid 0, frame_count 0, frame_err 0, laser_lost 0
- Threshold register:
  - threshold_wr loads the pending register in any state.
  - det_threshold <= pending only in ARM, so it never changes mid-frame.
  - A write coinciding with ARM is taken this arm (write-through).
- det_en (combinational): pix_valid && (state==ACTIVE || (state==WAIT_SOF && sof)), so the first pixel is enabled.
- States:
  - IDLE: enable=1 -> ARM.
  - ARM (1 cycle): det_reset_n=0, load shadow threshold -> WAIT_SOF.
  - WAIT_SOF: pix_valid&sof&eof -> DRAIN; pix_valid&sof -> ACTIVE.
  - ACTIVE:
    - pix_valid&eof -> DRAIN.
    - pix_valid&sof without eof (truncated frame) -> set frame_err, go to ARM; that sof is dropped and no result is published.
  - DRAIN: exactly 2 cycles for the detector's output pipeline; det_en=0 -> REPORT.
  - REPORT (1 cycle):
    - result_valid=1, laser_found<=det_found, frame_count<=frame_count+1 (wraps).
    - laser_xy<=det_xy if det_found, else hold.
    - Next: !enable -> IDLE; skip==0 -> ARM; else SKIP with skip_cnt<=skip.
  - SKIP: each pix_valid&eof decrements skip_cnt; at skip_cnt==1 with eof -> ARM.
- enable low:
  - From WAIT_SOF, ACTIVE or SKIP -> IDLE next cycle; frame aborted, no result_valid.
  - From ARM or DRAIN: complete to REPORT/WAIT_SOF first, then exit as above.
- skip is sampled only in REPORT; changes mid-skip take effect next period.
- frame_err cleared only by reset or by entering IDLE.
- reset mid-frame: every output returns to its reset value next cycle; the next enabled frame re-arms from IDLE.

Optional Feature:
- Macro: LASER_FRAME_CTRL_TIMEOUT_EN
- Defined:
  - 8-bit miss counter increments in REPORT when !det_found (saturating) and clears when det_found.
  - When the counter reaches MISS_LIMIT: laser_lost=1 and laser_xy<=0.
  - The next found frame clears laser_lost and loads det_xy.
- Undefined: laser_lost tied 0; no counter; laser_xy holds the last found value indefinitely.

Test Plan:
- Reset, enable=1, 4x2 frame, det_found=1, det_xy=32'h0002_0001 -> one det_reset_n low pulse, det_en high for 8 pixels, result_valid 2 cycles after the DRAIN entry +1, laser_xy=32'h0002_0001, frame_count=1.
- threshold_wr 8'd90 mid-ACTIVE -> det_threshold stays 200 until the next ARM, then 90.
- skip=2, five back-to-back frames -> frames 1 and 4 processed (det_en active), frame_count=2, no det_en during frames 2, 3, 5's skip window.
- sof during ACTIVE without eof -> frame_err=1, no result_valid, re-arm, next frame reports normally, frame_err stays 1 until enable drops.
- Enable dropped mid-ACTIVE -> IDLE next cycle, busy=0, no result_valid, frame_err cleared.
- LASER_FRAME_CTRL_TIMEOUT_EN, MISS_LIMIT=8, 8 frames with det_found=0 -> laser_lost=1 and laser_xy=0 after the 8th REPORT; one found frame -> laser_lost=0.
